// File: rtl/wca_pkg.sv
// wca_pkg: shared definitions for the weight cache access block.
//   - configuration ISA encodings (bit 1 set selects dense mode)
//   - default hit-table depth
//   - FSM state type, exported on the top-level debug port
package wca_pkg;

    localparam logic [1:0] ISA_SPARSE_RELOAD = 2'b00;
    localparam logic [1:0] ISA_SPARSE_KEEP   = 2'b01;
    localparam logic [1:0] ISA_DENSE         = 2'b10; // 2'b11 is also dense

    localparam int HIT_ADDR_WIDTH_DEF = 5;
    localparam int TBL_DEPTH          = 1 << HIT_ADDR_WIDTH_DEF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } wca_state_e;

    // Dense mode is selected by the ISA's most significant bit.
    function automatic logic isa_is_dense(input logic [1:0] isa);
        return isa[1];
    endfunction

endpackage

// File: rtl/wca_rr_arb.sv
// wca_rr_arb: round-robin arbiter over NUM_PORT requesters.
//   req_i      per-port request (already filtered for eligibility)
//   hold_i     the current grant was offered but not taken this cycle
//   adv_i      the current grant was taken; pointer moves past it
//   gnt_vld_o  some port is granted
//   gnt_idx_o  index of the granted port
// NUM_PORT must be a power of two so the pointer wraps naturally.
module wca_rr_arb #(
    parameter int NUM_PORT = 4,
    parameter int PW       = $clog2(NUM_PORT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PORT-1:0] req_i,
    input  logic                hold_i,
    input  logic                adv_i,
    output logic                gnt_vld_o,
    output logic [PW-1:0]       gnt_idx_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [PW-1:0] lock_idx_q, lock_idx_d;
    logic [PW-1:0] cand;

    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        cand      = '0;
        if (lock_q && req_i[lock_idx_q]) begin
            // A held grant keeps its port until it is taken.
            gnt_vld_o = 1'b1;
            gnt_idx_o = lock_idx_q;
        end else begin
            // Descending scan: the smallest offset from the pointer wins.
            for (int i = NUM_PORT - 1; i >= 0; i--) begin
                cand = ptr_q + PW'(i);
                if (req_i[cand]) begin
                    gnt_vld_o = 1'b1;
                    gnt_idx_o = cand;
                end
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = 1'b0;
        lock_idx_d = lock_idx_q;
        if (adv_i) begin
            ptr_d = PW'(gnt_idx_o + 1'b1);
        end else if (hold_i) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/wca.sv
// wca: weight cache access between FBF (index stream), four PE-row weight
// ports and the Weight Buffer.
//   TOPWCA_Cfg*   configuration handshake (ISA selects reload/keep/dense)
//   FBFWCA_Idx*   nonzero-weight indices loaded into the hit table
//   PERWCA_Adr*   per-port weight requests; WCAPER_Dat* registered responses
//   WCAWBF_Adr*   WBF read request; WBFWCA_Dat* WBF read data
//   dbg_state_o / dbg_count_o  FSM state and hit-table fill level
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; a valid, once raised, holds its payload until the transfer.
module wca
    import wca_pkg::*;
#(
    parameter int ISA_WIDTH      = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int WEI_ADDR_WIDTH = 8,
    parameter int HIT_ADDR_WIDTH = HIT_ADDR_WIDTH_DEF,
    parameter int NUM_PORT       = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                TOPWCA_CfgVld,
    input  logic [ISA_WIDTH-1:0]                TOPWCA_CfgISA,
    output logic                                WCATOP_CfgRdy,
    input  logic                                FBFWCA_IdxVld,
    input  logic [WEI_ADDR_WIDTH-1:0]           FBFWCA_Idx,
    output logic                                WCAFBF_IdxRdy,
    input  logic [NUM_PORT-1:0]                 PERWCA_AdrVld,
    input  logic [NUM_PORT*WEI_ADDR_WIDTH-1:0]  PERWCA_Adr,
    output logic [NUM_PORT-1:0]                 WCAPER_AdrRdy,
    output logic [NUM_PORT-1:0]                 WCAPER_DatVld,
    output logic [NUM_PORT*DATA_WIDTH-1:0]      WCAPER_Dat,
    input  logic [NUM_PORT-1:0]                 PERWCA_DatRdy,
    output logic                                WCAWBF_AdrVld,
    output logic [WEI_ADDR_WIDTH-1:0]           WCAWBF_Adr,
    input  logic                                WBFWCA_AdrRdy,
    input  logic                                WBFWCA_DatVld,
    input  logic [DATA_WIDTH-1:0]               WBFWCA_Dat,
    output logic                                WCAWBF_DatRdy,
    output wca_state_e                          dbg_state_o,
    output logic [HIT_ADDR_WIDTH:0]             dbg_count_o
);

    localparam int DEPTH = 1 << HIT_ADDR_WIDTH;
    localparam int PW    = $clog2(NUM_PORT);

    wca_state_e                 state_q, state_d;
    logic                       dense_q, dense_d;
    logic [HIT_ADDR_WIDTH:0]    count_q, count_d;
    logic [WEI_ADDR_WIDTH-1:0]  entry_q [DEPTH];
    logic                       outst_q, outst_d;
    logic [PW-1:0]              owner_q, owner_d;
    logic [NUM_PORT-1:0]        busy_q, busy_d, dvld_q, dvld_d;
    logic [DATA_WIDTH-1:0]      dat_q [NUM_PORT];
    logic [DATA_WIDTH-1:0]      dat_d [NUM_PORT];

    logic                       active, cfg_hs, idx_hs;
    logic [WEI_ADDR_WIDTH-1:0]  port_adr [NUM_PORT];
    logic [WEI_ADDR_WIDTH-1:0]  wbf_adr  [NUM_PORT];
    logic [HIT_ADDR_WIDTH-1:0]  hit_idx  [NUM_PORT];
    logic [NUM_PORT-1:0]        hit, elig;
    logic                       gnt_vld, hit_g, accept, hold;
    logic [PW-1:0]              gnt_idx;

    assign active        = (state_q == ST_ACTIVE);
    assign WCATOP_CfgRdy = ~(|busy_q) & ~outst_q;
    assign cfg_hs        = TOPWCA_CfgVld & WCATOP_CfgRdy;
    assign WCAFBF_IdxRdy = active & ~dense_q
                         & (count_q < (HIT_ADDR_WIDTH + 1)'(DEPTH));
    assign idx_hs        = FBFWCA_IdxVld & WCAFBF_IdxRdy;
    assign WCAWBF_DatRdy = outst_q;
    assign dbg_state_o   = state_q;
    assign dbg_count_o   = count_q;

    // Per-port CAM lookup. Only entries below count_q are live, so an index
    // written this cycle cannot hit until the next one.
    always_comb begin
        for (int p = 0; p < NUM_PORT; p++) begin
            port_adr[p] = PERWCA_Adr[p*WEI_ADDR_WIDTH +: WEI_ADDR_WIDTH];
            hit[p]      = 1'b0;
            hit_idx[p]  = '0;
            wbf_adr[p]  = port_adr[p];
            if (dense_q) begin
                hit[p] = 1'b1;
            end else begin
                // Descending scan so the lowest matching entry wins.
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (((HIT_ADDR_WIDTH + 1)'(i) < count_q) &&
                        (entry_q[i] == port_adr[p])) begin
                        hit[p]     = 1'b1;
                        hit_idx[p] = HIT_ADDR_WIDTH'(i);
                    end
                end
                wbf_adr[p] = WEI_ADDR_WIDTH'(hit_idx[p]);
            end
            // Hits need the single WBF read slot; misses do not.
            elig[p] = active & PERWCA_AdrVld[p] & ~busy_q[p] & ~cfg_hs
                    & (~hit[p] | ~outst_q);
        end
    end

    wca_rr_arb #(.NUM_PORT(NUM_PORT), .PW(PW)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (elig),
        .hold_i    (hold),
        .adv_i     (accept),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // WCAWBF_AdrVld is formed without looking at WBFWCA_AdrRdy.
    always_comb begin
        hit_g         = hit[gnt_idx];
        WCAWBF_AdrVld = gnt_vld & hit_g;
        WCAWBF_Adr    = WCAWBF_AdrVld ? wbf_adr[gnt_idx] : '0;
        accept        = gnt_vld & (~hit_g | WBFWCA_AdrRdy);
        hold          = gnt_vld & hit_g & ~WBFWCA_AdrRdy;
        WCAPER_AdrRdy = '0;
        if (accept) WCAPER_AdrRdy[gnt_idx] = 1'b1;
        for (int p = 0; p < NUM_PORT; p++) begin
            WCAPER_Dat[p*DATA_WIDTH +: DATA_WIDTH] = dat_q[p];
        end
        WCAPER_DatVld = dvld_q;
    end

    // FSM next state plus bookkeeping for table, ports and WBF read slot.
    always_comb begin
        state_d = state_q;
        dense_d = dense_q;
        count_d = count_q;
        outst_d = outst_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        dvld_d  = dvld_q;
        dat_d   = dat_q;

        if (cfg_hs) begin
            state_d = ST_ACTIVE;
            dense_d = isa_is_dense(TOPWCA_CfgISA[1:0]);
        end

        if (cfg_hs && (TOPWCA_CfgISA[1:0] == ISA_SPARSE_RELOAD)) begin
            count_d = '0;
        end else if (idx_hs) begin
            count_d = count_q + 1'b1;
        end

        for (int p = 0; p < NUM_PORT; p++) begin
            if (dvld_q[p] && PERWCA_DatRdy[p]) begin
                dvld_d[p] = 1'b0;
                busy_d[p] = 1'b0;
            end
        end

        if (outst_q && WBFWCA_DatVld) begin
            dvld_d[owner_q] = 1'b1;
            dat_d[owner_q]  = WBFWCA_Dat;
            outst_d         = 1'b0;
        end

        if (accept) begin
            busy_d[gnt_idx] = 1'b1;
            if (hit_g) begin
                outst_d = 1'b1;
                owner_d = gnt_idx;
            end else begin
                dvld_d[gnt_idx] = 1'b1;
                dat_d[gnt_idx]  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dense_q <= 1'b0;
            count_q <= '0;
            outst_q <= 1'b0;
            owner_q <= '0;
            busy_q  <= '0;
            dvld_q  <= '0;
            for (int p = 0; p < NUM_PORT; p++) dat_q[p] <= '0;
        end else begin
            state_q <= state_d;
            dense_q <= dense_d;
            count_q <= count_d;
            outst_q <= outst_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            dvld_q  <= dvld_d;
            dat_q   <= dat_d;
        end
    end

    // Table storage needs no reset: entries at or above count_q are ignored.
    always_ff @(posedge clk) begin
        if (idx_hs) entry_q[count_q[HIT_ADDR_WIDTH-1:0]] <= FBFWCA_Idx;
    end

endmodule

// File: tb/tb_wca.sv
module tb_wca;
    import wca_pkg::*;

    logic        clk, rst_n;
    logic        cfg_vld, cfg_rdy;
    logic [1:0]  cfg_isa;
    logic        idx_vld, idx_rdy;
    logic [7:0]  idx;
    logic [3:0]  adr_vld, adr_rdy, dat_vld, dat_rdy;
    logic [31:0] adr, dat;
    logic        wbf_adr_vld, wbf_adr_rdy, wbf_dat_vld, wbf_dat_rdy;
    logic [7:0]  wbf_adr, wbf_dat;
    wca_state_e  dbg_state;
    logic [5:0]  dbg_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int n_acc;
    logic [7:0] idx_tab [3];

    wca dut (
        .clk(clk), .rst_n(rst_n),
        .TOPWCA_CfgVld(cfg_vld), .TOPWCA_CfgISA(cfg_isa), .WCATOP_CfgRdy(cfg_rdy),
        .FBFWCA_IdxVld(idx_vld), .FBFWCA_Idx(idx), .WCAFBF_IdxRdy(idx_rdy),
        .PERWCA_AdrVld(adr_vld), .PERWCA_Adr(adr), .WCAPER_AdrRdy(adr_rdy),
        .WCAPER_DatVld(dat_vld), .WCAPER_Dat(dat), .PERWCA_DatRdy(dat_rdy),
        .WCAWBF_AdrVld(wbf_adr_vld), .WCAWBF_Adr(wbf_adr), .WBFWCA_AdrRdy(wbf_adr_rdy),
        .WBFWCA_DatVld(wbf_dat_vld), .WBFWCA_Dat(wbf_dat), .WCAWBF_DatRdy(wbf_dat_rdy),
        .dbg_state_o(dbg_state), .dbg_count_o(dbg_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; cfg_vld = 0; cfg_isa = 0; idx_vld = 0; idx = 0;
        adr_vld = 0; adr = 0; dat_rdy = 4'hF; wbf_adr_rdy = 1;
        wbf_dat_vld = 0; wbf_dat = 0;
        idx_tab[0] = 8'd5; idx_tab[1] = 8'd9; idx_tab[2] = 8'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cfg_rdy", cfg_rdy, 1);
        chk("rst_idx_rdy", idx_rdy, 0);
        chk("rst_dat_vld", dat_vld, 0);
        chk("rst_dat", dat, 0);
        chk("rst_adr_rdy", adr_rdy, 0);
        chk("rst_wbf_adr_vld", wbf_adr_vld, 0);
        chk("rst_wbf_adr", wbf_adr, 0);
        chk("rst_wbf_dat_rdy", wbf_dat_rdy, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        tick;

        // Sparse reload, then load 5, 9, 5
        cfg_vld = 1; cfg_isa = 2'b00;
        #1 chk("cfg00_rdy", cfg_rdy, 1);
        tick; cfg_vld = 0;
        #1 chk("cfg00_state", dbg_state, ST_ACTIVE);
        chk("cfg00_idx_rdy", idx_rdy, 1);
        chk("cfg00_count", dbg_count, 0);
        idx_vld = 1;
        for (int i = 0; i < 3; i++) begin
            idx = idx_tab[i];
            tick;
        end
        idx_vld = 0;
        #1 chk("load3_count", dbg_count, 3);

        // Port 2 hit on 9 -> WBF address 1, data 0xA7
        adr_vld = 4'b0100; adr[23:16] = 8'd9;
        #1 chk("hit9_wbf_vld", wbf_adr_vld, 1);
        chk("hit9_wbf_adr", wbf_adr, 1);
        chk("hit9_adr_rdy", adr_rdy, 4'b0100);
        tick; adr_vld = 0;
        #1 chk("hit9_dat_rdy", wbf_dat_rdy, 1);
        chk("hit9_no_vld_yet", dat_vld, 0);
        chk("hit9_cfg_rdy_busy", cfg_rdy, 0);
        wbf_dat_vld = 1; wbf_dat = 8'hA7;
        tick; wbf_dat_vld = 0;
        #1 chk("hit9_dat_vld", dat_vld, 4'b0100);
        chk("hit9_dat", dat[23:16], 8'hA7);
        chk("hit9_slot_free", wbf_dat_rdy, 0);
        tick;
        #1 chk("hit9_released", dat_vld, 0);
        chk("hit9_cfg_rdy", cfg_rdy, 1);

        // Port 0 hit on 5 -> lowest entry 0
        adr_vld = 4'b0001; adr[7:0] = 8'd5;
        #1 chk("hit5_wbf_adr", wbf_adr, 0);
        chk("hit5_wbf_vld", wbf_adr_vld, 1);
        chk("hit5_adr_rdy", adr_rdy, 4'b0001);
        tick; adr_vld = 0; wbf_dat_vld = 1; wbf_dat = 8'h3C;
        tick; wbf_dat_vld = 0;
        #1 chk("hit5_dat_vld", dat_vld, 4'b0001);
        chk("hit5_dat", dat[7:0], 8'h3C);
        tick;

        // Port 1 miss on 7 -> zero at T+1, no WBF read
        adr_vld = 4'b0010; adr[15:8] = 8'd7;
        #1 chk("miss7_wbf_vld", wbf_adr_vld, 0);
        chk("miss7_adr_rdy", adr_rdy, 4'b0010);
        tick; adr_vld = 0;
        #1 chk("miss7_dat_vld", dat_vld, 4'b0010);
        chk("miss7_dat", dat[15:8], 0);
        chk("miss7_no_slot", wbf_dat_rdy, 0);
        tick;

        // Port 3 miss brings the pointer back to port 0
        adr_vld = 4'b1000; adr[31:24] = 8'd7;
        #1 chk("miss_p3_adr_rdy", adr_rdy, 4'b1000);
        tick; adr_vld = 0;
        tick;

        // All four ports miss together; port 1 holds its response
        adr = {8'd200, 8'd100, 8'd8, 8'd7}; adr_vld = 4'hF; dat_rdy = 4'b1101;
        #1 chk("rr_gnt0", adr_rdy, 4'b0001);
        tick; adr_vld[0] = 0;
        #1 chk("rr_gnt1", adr_rdy, 4'b0010);
        chk("rr_vld_a", dat_vld, 4'b0001);
        tick; adr_vld[1] = 0;
        #1 chk("rr_gnt2", adr_rdy, 4'b0100);
        chk("rr_vld_b", dat_vld, 4'b0010);
        tick; adr_vld[2] = 0;
        #1 chk("rr_gnt3", adr_rdy, 4'b1000);
        chk("rr_vld_c", dat_vld, 4'b0110);
        tick; adr_vld[3] = 0;
        #1 chk("rr_vld_d", dat_vld, 4'b1010);
        adr_vld = 4'b0011;
        #1 chk("blk_p0_ok", adr_rdy, 4'b0001);
        tick; adr_vld[0] = 0;
        #1 chk("blk_p1_busy", adr_rdy, 4'b0000);
        chk("blk_vld", dat_vld, 4'b0011);
        chk("blk_cfg_rdy", cfg_rdy, 0);
        dat_rdy = 4'hF;
        tick;
        #1 chk("unblk_vld", dat_vld, 4'b0000);
        chk("unblk_p1_rdy", adr_rdy, 4'b0010);
        tick; adr_vld = 0;
        #1 chk("unblk_p1_resp", dat_vld, 4'b0010);
        tick;
        #1 chk("unblk_cfg_rdy", cfg_rdy, 1);

        // Fill table: 40 offered, 32 taken
        cfg_vld = 1; cfg_isa = 2'b00;
        tick; cfg_vld = 0;
        #1 chk("fill_count0", dbg_count, 0);
        n_acc = 0; idx_vld = 1;
        for (int i = 0; i < 40; i++) begin
            idx = 8'(10 + i);
            #1 if (idx_rdy) n_acc++;
            tick;
        end
        idx_vld = 0;
        #1 chk("fill_accepted", n_acc, 32);
        chk("fill_idx_rdy", idx_rdy, 0);
        chk("fill_count", dbg_count, 32);
        adr_vld = 4'b0001; adr[7:0] = 8'd41;
        #1 chk("fill_last_adr", wbf_adr, 8'h1F);
        chk("fill_last_vld", wbf_adr_vld, 1);
        adr_vld = 0;

        // Keep retains the table
        cfg_vld = 1; cfg_isa = 2'b01;
        tick; cfg_vld = 0;
        #1 chk("keep_count", dbg_count, 32);
        chk("keep_idx_rdy", idx_rdy, 0);
        adr_vld = 4'b0001; adr[7:0] = 8'd12;
        #1 chk("keep_hit_adr", wbf_adr, 2);
        adr_vld = 0;

        // Reload clears it
        cfg_vld = 1; cfg_isa = 2'b00;
        tick; cfg_vld = 0;
        #1 chk("reload_count", dbg_count, 0);
        chk("reload_idx_rdy", idx_rdy, 1);
        adr_vld = 4'b0001;
        #1 chk("reload_miss_vld", wbf_adr_vld, 0);
        chk("reload_miss_rdy", adr_rdy, 4'b0001);
        adr_vld = 0;

        // Index write and lookup of the same value in one cycle
        idx_vld = 1; idx = 8'h55; adr_vld = 4'b0001; adr[7:0] = 8'h55;
        #1 chk("same_cyc_miss", wbf_adr_vld, 0);
        adr_vld = 0;
        tick; idx_vld = 0; adr_vld = 4'b0001;
        #1 chk("next_cyc_hit", wbf_adr_vld, 1);
        chk("next_cyc_adr", wbf_adr, 0);
        adr_vld = 0;

        // Config wins over a request; switch to dense
        cfg_vld = 1; cfg_isa = 2'b10; adr_vld = 4'b0001;
        #1 chk("cfgwin_adr_rdy", adr_rdy, 0);
        chk("cfgwin_wbf_vld", wbf_adr_vld, 0);
        chk("cfgwin_cfg_rdy", cfg_rdy, 1);
        tick; cfg_vld = 0; adr_vld = 0;
        #1 chk("dense_idx_rdy", idx_rdy, 0);

        // Dense passthrough with WBF back-pressure for 3 cycles
        adr[23:16] = 8'h7F; adr[31:24] = 8'h33; adr_vld = 4'b1100; wbf_adr_rdy = 0;
        #1 chk("dense_wbf_vld", wbf_adr_vld, 1);
        chk("dense_wbf_adr", wbf_adr, 8'h7F);
        chk("dense_hold_rdy", adr_rdy, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("dense_hold_adr", wbf_adr, 8'h7F);
            chk("dense_hold_rdy", adr_rdy, 0);
        end
        wbf_adr_rdy = 1;
        #1 chk("dense_take_rdy", adr_rdy, 4'b0100);
        tick; adr_vld[2] = 0;
        #1 chk("dense_slot_busy_vld", wbf_adr_vld, 0);
        chk("dense_slot_busy_rdy", adr_rdy, 0);
        chk("dense_dat_rdy", wbf_dat_rdy, 1);
        wbf_dat_vld = 1; wbf_dat = 8'h5A;
        tick; wbf_dat_vld = 0;
        #1 chk("dense_p2_vld", dat_vld, 4'b0100);
        chk("dense_p2_dat", dat[23:16], 8'h5A);
        chk("dense_p3_adr", wbf_adr, 8'h33);
        chk("dense_p3_rdy", adr_rdy, 4'b1000);
        tick; adr_vld = 0; wbf_dat_vld = 1; wbf_dat = 8'h66;
        tick; wbf_dat_vld = 0;
        #1 chk("dense_p3_vld", dat_vld, 4'b1000);
        chk("dense_p3_dat", dat[31:24], 8'h66);
        tick;

        // Reset while a WBF read is outstanding
        adr_vld = 4'b0001; adr[7:0] = 8'h11;
        tick; adr_vld = 0;
        #1 chk("midrst_pre_slot", wbf_dat_rdy, 1);
        rst_n = 1'b0;
        #1 chk("midrst_slot", wbf_dat_rdy, 0);
        chk("midrst_state", dbg_state, ST_IDLE);
        chk("midrst_count", dbg_count, 0);
        chk("midrst_cfg_rdy", cfg_rdy, 1);
        chk("midrst_dat_vld", dat_vld, 0);
        #1 rst_n = 1'b1;
        tick;
        adr_vld = 4'b0001;
        #1 chk("idle_no_accept", adr_rdy, 0);
        adr_vld = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
